// File: rtl/solver_launcher_if.sv
// ---------------------------------------------------------------------------
// solver_launcher_if
//
// Host-side handshake bundle for the SAT solver launcher. It carries the
// solve request channel, the host abort line and the response channel.
//
// Signals:
//   req_valid   host -> launcher  host has a solve request
//   req_ready   launcher -> host  launcher can accept a request (IDLE only)
//   req_limit   host -> launcher  timeout in WAIT cycles, 0 = no timeout
//   abort       host -> launcher  abandon the current run
//   rsp_valid   launcher -> host  response available
//   rsp_ready   host -> launcher  host accepts the response
//   rsp_status  launcher -> host  0=SAT 1=UNSAT 2=TIMEOUT 3=ABORTED 4=ERROR
//   rsp_cycles  launcher -> host  WAIT cycles consumed by the run
//
// Modports:
//   master  the host side (drives requests, consumes responses)
//   slave   the launcher side
// ---------------------------------------------------------------------------
interface solver_launcher_if #(
    parameter int LIMIT_W = 32,
    parameter int CYC_W   = 32
);

    logic               req_valid;
    logic               req_ready;
    logic [LIMIT_W-1:0] req_limit;
    logic               abort;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2:0]         rsp_status;
    logic [CYC_W-1:0]   rsp_cycles;

    // The host drives the request side and the response acknowledge.
    modport master (
        output req_valid,
        output req_limit,
        output abort,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_status,
        input  rsp_cycles
    );

    // The launcher consumes requests and produces responses.
    modport slave (
        input  req_valid,
        input  req_limit,
        input  abort,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_status,
        output rsp_cycles
    );

endinterface

// File: rtl/solver_launcher.sv
// ---------------------------------------------------------------------------
// solver_launcher
//
// Host-side initiator for the SAT solver control block. A solve request is
// accepted over a valid/ready handshake, the solver is kicked with a single
// cycle start pulse, and the launcher then waits for the solver to report
// sat/unsat. The wait is bounded by an optional per-request watchdog limit
// and can be cut short by a host abort. The outcome and the number of WAIT
// cycles consumed are returned over a valid/ready response handshake.
//
// Parameters:
//   LIMIT_W  width of the per-request timeout limit
//   CYC_W    width of the elapsed-cycle counter (saturates at all-ones)
//
// Ports:
//   clock         system clock, all state updates on posedge
//   reset         asynchronous active-high reset, returns to IDLE
//   host          solver_launcher_if.slave request/abort/response bundle
//   solver_start  one-cycle start pulse to the solver (LAUNCH state)
//   solver_sat    solver reports satisfiable
//   solver_unsat  solver reports unsatisfiable
//   solver_abort  one-cycle pulse telling the solver to abandon the run
//   busy          high while a request is in flight (LAUNCH, WAIT, RESP)
//   err_spurious  sticky flag, solver result seen outside WAIT
// ---------------------------------------------------------------------------
module solver_launcher #(
    parameter int LIMIT_W = 32,
    parameter int CYC_W   = 32
) (
    input  logic                clock,
    input  logic                reset,
    solver_launcher_if.slave    host,
    output logic                solver_start,
    input  logic                solver_sat,
    input  logic                solver_unsat,
    output logic                solver_abort,
    output logic                busy,
    output logic                err_spurious
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ST_SAT     = 3'd0,
        ST_UNSAT   = 3'd1,
        ST_TIMEOUT = 3'd2,
        ST_ABORTED = 3'd3,
        ST_ERROR   = 3'd4
    } status_t;

    // The timeout compare works on a common width so that a limit wider
    // than the counter (or the other way round) still compares correctly.
    localparam int CMP_W = (LIMIT_W > CYC_W) ? LIMIT_W : CYC_W;

    state_t             state_q;
    state_t             state_d;
    status_t            status_q;
    status_t            status_d;
    logic [CYC_W-1:0]   count_q;
    logic [CYC_W-1:0]   count_d;
    logic [CYC_W-1:0]   count_inc;
    logic [CYC_W-1:0]   cycles_q;
    logic [CYC_W-1:0]   cycles_d;
    logic [LIMIT_W-1:0] limit_q;
    logic [LIMIT_W-1:0] limit_d;
    logic               pulse_q;
    logic               pulse_d;
    logic               err_q;
    logic               err_d;
    logic [CMP_W-1:0]   n_ext;
    logic [CMP_W-1:0]   limit_ext;
    logic               limit_hit;
    logic               wait_done;

    // The value the counter would take this WAIT cycle ("n"). It sticks at
    // all-ones so a run with no limit can wait forever without wrapping and
    // without ever reporting a bogus small cycle count.
    always_comb begin
        count_inc = count_q;
        if (!(&count_q)) begin
            count_inc = count_q + CYC_W'(1);
        end
    end

    // Watchdog compare. A latched limit of zero disables the watchdog, so a
    // saturated counter is never compared against it.
    always_comb begin
        n_ext     = CMP_W'(count_inc);
        limit_ext = CMP_W'(limit_q);
        limit_hit = (limit_q != '0) && (n_ext == limit_ext);
    end

    // Next-state and datapath decode. Everything the FSM updates has its
    // hold value assigned first, then each state overrides only what it
    // changes. In WAIT the checks run in priority order: a solver result
    // always wins over an abort arriving in the same cycle, and an abort
    // wins over the watchdog, so the host always sees the most informative
    // outcome. The solver_abort pulse is scheduled only for outcomes where
    // the solver may still be running (timeout or host abort).
    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        count_d   = count_q;
        cycles_d  = cycles_q;
        limit_d   = limit_q;
        pulse_d   = 1'b0;
        wait_done = 1'b0;
        err_d     = err_q;

        if ((solver_sat || solver_unsat) && (state_q != WAIT)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (host.req_valid) begin
                    limit_d = host.req_limit;
                    count_d = '0;
                    state_d = LAUNCH;
                end
            end

            LAUNCH: begin
                if (host.abort) begin
                    status_d = ST_ABORTED;
                    cycles_d = '0;
                    pulse_d  = 1'b1;
                    state_d  = RESP;
                end else begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                wait_done = 1'b1;
                if (solver_sat && solver_unsat) begin
                    status_d = ST_ERROR;
                end else if (solver_sat) begin
                    status_d = ST_SAT;
                end else if (solver_unsat) begin
                    status_d = ST_UNSAT;
                end else if (host.abort) begin
                    status_d = ST_ABORTED;
                    pulse_d  = 1'b1;
                end else if (limit_hit) begin
                    status_d = ST_TIMEOUT;
                    pulse_d  = 1'b1;
                end else begin
                    wait_done = 1'b0;
                    count_d   = count_inc;
                end

                if (wait_done) begin
                    cycles_d = count_inc;
                    state_d  = RESP;
                end
            end

            RESP: begin
                if (host.rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset can land in any state, including mid-run, and
    // clears every piece of run context so the next request starts clean.
    // The abort pulse register is only ever set on the edge that enters
    // RESP, so it is high for exactly the first RESP cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= ST_SAT;
            count_q  <= '0;
            cycles_q <= '0;
            limit_q  <= '0;
            pulse_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            count_q  <= count_d;
            cycles_q <= cycles_d;
            limit_q  <= limit_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
        end
    end

    // Outputs are Moore-decoded from the state or taken straight from
    // registers, so no input can ripple through to an output in the same
    // cycle. Status and cycle count simply hold their last value outside
    // RESP; they are only meaningful while rsp_valid is high.
    assign host.req_ready  = (state_q == IDLE);
    assign host.rsp_valid  = (state_q == RESP);
    assign host.rsp_status = status_q;
    assign host.rsp_cycles = cycles_q;
    assign solver_start    = (state_q == LAUNCH);
    assign solver_abort    = pulse_q;
    assign busy            = (state_q != IDLE);
    assign err_spurious    = err_q;

endmodule
